// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: bus between the execute-stage control and the mult/div unit.
//   start, op, a, b   : operation request (op 00 mult, 01 multu, 10 div, 11 divu)
//   hi_we, lo_we, wd  : mthi / mtlo writes
//   busy, done        : status back to control (stall while busy, done pulses)
//   hi, lo            : architectural HI/LO registers
// master drives requests (control side), slave is the unit itself.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wd;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, hi_we, lo_we, wd,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, wd,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MIPS mult/multu/div/divu unit holding HI/LO.
// An operation takes WIDTH+1 cycles: WIDTH iterations on magnitudes, then a
// sign-fix cycle that writes HI/LO. mthi/mtlo load HI/LO directly in idle.
// Ports:
//   clk   : clock, all state changes on posedge
//   reset : asynchronous, active-high
//   bus   : muldiv_unit_if slave (start/op/a/b, hi_we/lo_we/wd, busy/done/hi/lo)
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           reset,
  muldiv_unit_if.slave   bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  state_t             state;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH-1:0]   orig_a;
  logic               qsign;
  logic               rsign;
  logic               div_zero;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      count;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               busy_q;
  logic               done_q;

  // Operand conditioning at start: magnitudes for signed ops.
  // The most negative value negates to itself, which read as unsigned is
  // exactly its magnitude, so no special case is needed.
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;

  // Per-iteration datapath.
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_trial;
  logic               div_ok;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] step_acc;

  // Sign-fixed results for the final cycle.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  always_comb begin
    a_neg = ~bus.op[0] & bus.a[WIDTH-1];
    b_neg = ~bus.op[0] & bus.b[WIDTH-1];
    abs_a = a_neg ? -bus.a : bus.a;
    abs_b = b_neg ? -bus.b : bus.b;
  end

  // Multiply: add the multiplicand into the upper half when the current
  // multiplier bit is set, then shift the whole accumulator right; low
  // product bits drift down into the lower half.
  // Divide: the upper half is the partial remainder, the lower half collects
  // quotient bits; the dividend is fed in MSB first from mag_a. A clear top
  // bit of the WIDTH+1-bit trial difference means the subtract succeeded.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (mag_b[0] ? mag_a : '0)};
    div_shift = {acc[2*WIDTH-1:WIDTH], mag_a[WIDTH-1]};
    div_trial = div_shift - {1'b0, mag_b};
    div_ok    = ~div_trial[WIDTH];
    div_rem   = div_ok ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
    if (op_q[1]) begin
      step_acc = {div_rem, acc[WIDTH-2:0], div_ok};
    end else begin
      step_acc = {mul_sum, acc[WIDTH-1:1]};
    end
  end

  // Sign correction; qsign/rsign are only ever set for signed ops.
  // Divide by zero overrides everything with all-ones / original dividend.
  always_comb begin
    prod_fix = qsign ? -acc : acc;
    quo_fix  = qsign ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = rsign ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    if (!op_q[1]) begin
      res_hi = prod_fix[2*WIDTH-1:WIDTH];
      res_lo = prod_fix[WIDTH-1:0];
    end else if (div_zero) begin
      res_hi = orig_a;
      res_lo = '1;
    end else begin
      res_hi = rem_fix;
      res_lo = quo_fix;
    end
  end

  // Main state machine: IDLE accepts start (or mthi/mtlo), CALC runs WIDTH
  // iterations, FIX writes HI/LO and pulses done. Requests and HI/LO writes
  // arriving while busy are simply not looked at.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      op_q     <= '0;
      mag_a    <= '0;
      mag_b    <= '0;
      orig_a   <= '0;
      qsign    <= 1'b0;
      rsign    <= 1'b0;
      div_zero <= 1'b0;
      acc      <= '0;
      count    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_q     <= bus.op;
            mag_a    <= abs_a;
            mag_b    <= abs_b;
            orig_a   <= bus.a;
            qsign    <= a_neg ^ b_neg;
            rsign    <= a_neg;
            div_zero <= (bus.b == '0);
            acc      <= '0;
            count    <= '0;
            busy_q   <= 1'b1;
            state    <= CALC;
          end else begin
            if (bus.hi_we) hi_q <= bus.wd;
            if (bus.lo_we) lo_q <= bus.wd;
          end
        end
        CALC: begin
          acc <= step_acc;
          if (op_q[1]) begin
            mag_a <= {mag_a[WIDTH-2:0], 1'b0};
          end else begin
            mag_b <= {1'b0, mag_b[WIDTH-1:1]};
          end
          count <= count + CW'(1);
          if (count == CW'(WIDTH-1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          hi_q   <= res_hi;
          lo_q   <= res_lo;
          busy_q <= 1'b0;
          done_q <= 1'b1;
          state  <= IDLE;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: self-checking bench for muldiv_unit.
// A behavioural model (plain 64-bit arithmetic plus a remaining-cycles count)
// tracks the expected HI/LO/busy/done; a compare process checks the DUT
// against it every negedge. Directed cases add literal expectations.
module tb_muldiv_unit;

  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic reset;

  muldiv_unit_if #(.WIDTH(WIDTH)) bus ();

  muldiv_unit #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model state.
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  logic        m_done;
  int          m_rem;

  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Result rules straight from the instruction definitions.
  task automatic compute(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] rh, output logic [31:0] rl);
    longint      sa, sb;
    logic [63:0] p, ua, ub;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      2'b00: p = sa * sb;
      2'b01: p = ua * ub;
      2'b10: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else        p = {32'(sa % sb), 32'(sa / sb)};
      end
      default: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else        p = {32'(ua % ub), 32'(ua / ub)};
      end
    endcase
    rh = p[63:32];
    rl = p[31:0];
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_hi   = 0;
      m_lo   = 0;
      m_done = 0;
      m_rem  = 0;
    end else begin
      m_done = 0;
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) begin
          m_hi   = p_hi;
          m_lo   = p_lo;
          m_done = 1;
        end
      end else if (bus.start) begin
        compute(bus.op, bus.a, bus.b, p_hi, p_lo);
        m_rem = WIDTH + 1;
      end else begin
        if (bus.hi_we) m_hi = bus.wd;
        if (bus.lo_we) m_lo = bus.wd;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      check1("busy", {31'b0, bus.busy}, {31'b0, (m_rem > 0)});
      check1("done", {31'b0, bus.done}, {31'b0, m_done});
      check1("hi", bus.hi, m_hi);
      check1("lo", bus.lo, m_lo);
    end
  end

  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Called at the first negedge after the start edge; returns at the
  // negedge where done is seen.
  task automatic waitDone(input string name, output int busyCycles);
    bit seen = 0;
    busyCycles = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.busy) busyCycles++;
      if (bus.done) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s_timeout actual=no_done required=done_within_100", name);
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    check1({name, "_hi"}, bus.hi, exp_hi);
    check1({name, "_lo"}, bus.lo, exp_lo);
  endtask

  task automatic runOp(input string name, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int bc;
    applyStimulus(op, a, b);
    waitDone(name, bc);
    check1({name, "_busy_cycles"}, 32'(bc), 32'(WIDTH + 1));
    checkOutput(name, exp_hi, exp_lo);
    @(negedge clk);
    check1({name, "_done_pulse"}, {31'b0, bus.done}, 32'd0);
  endtask

  initial begin
    #1000000;
    failures++;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int bc;
    bus.start = 0; bus.op = 0; bus.a = 0; bus.b = 0;
    bus.hi_we = 0; bus.lo_we = 0; bus.wd = 0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset", 32'h0, 32'h0);
    check1("reset_busy", {31'b0, bus.busy}, 32'd0);
    check1("reset_done", {31'b0, bus.done}, 32'd0);
    #1 reset = 1'b0;

    runOp("mult",      2'b00, 32'hFFFF_FFFE, 32'h3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    runOp("multu",     2'b01, 32'hFFFF_FFFE, 32'h3, 32'h0000_0002, 32'hFFFF_FFFA);
    runOp("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    runOp("div_neg",   2'b10, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    runOp("divu",      2'b11, 32'd100, 32'd7, 32'd2, 32'd14);
    runOp("divu_zero", 2'b11, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF);
    runOp("div_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);

    // Second start plus mthi at cycle 10 of a mult must be ignored.
    applyStimulus(2'b00, 32'd5, 32'd6);
    repeat (9) @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b11; bus.a = 32'd999; bus.b = 32'd3;
    bus.hi_we = 1'b1; bus.wd = 32'h1234_5678;
    @(negedge clk);
    bus.start = 1'b0; bus.hi_we = 1'b0;
    waitDone("busy_ignore", bc);
    checkOutput("busy_ignore", 32'h0, 32'd30);
    @(negedge clk);
    bus.lo_we = 1'b1; bus.wd = 32'hCAFE_F00D;
    @(negedge clk);
    bus.lo_we = 1'b0;
    checkOutput("mtlo", 32'h0, 32'hCAFE_F00D);

    // Asynchronous reset in the middle of a divide.
    applyStimulus(2'b10, 32'd1000, 32'd7);
    repeat (14) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("async_reset", 32'h0, 32'h0);
    check1("async_reset_busy", {31'b0, bus.busy}, 32'd0);
    check1("async_reset_done", {31'b0, bus.done}, 32'd0);
    @(negedge clk);
    #1 reset = 1'b0;
    runOp("after_reset", 2'b00, 32'd3, 32'd4, 32'h0, 32'd12);

    // Start together with mthi/mtlo in idle: start wins.
    @(negedge clk);
    bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wd = 32'hDEAD_BEEF;
    runOp("start_and_write", 2'b01, 32'd7, 32'd9, 32'h0, 32'd63);
    bus.hi_we = 1'b0; bus.lo_we = 1'b0;

    // Random traffic: starts at any time (including while busy and on the
    // done cycle), random mthi/mtlo, occasional zero divisors and edge values.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      bus.start = ($urandom_range(0, 5) == 0);
      bus.op    = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 7))
        0:       bus.a = 32'h8000_0000;
        1:       bus.a = 32'hFFFF_FFFF;
        default: bus.a = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       bus.b = 32'h0;
        1:       bus.b = 32'hFFFF_FFFF;
        2:       bus.b = 32'($urandom_range(1, 15));
        default: bus.b = $urandom;
      endcase
      bus.hi_we = ($urandom_range(0, 5) == 0);
      bus.lo_we = ($urandom_range(0, 5) == 0);
      bus.wd    = $urandom;
    end
    @(negedge clk);
    bus.start = 0; bus.hi_we = 0; bus.lo_we = 0;
    repeat (WIDTH + 5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit in the execute stage, beside the ALU.
- Executes MIPS mult, multu, div and divu in WIDTH+1 cycles and holds the results in architectural HI/LO registers.
- Control stalls on busy. mfhi/mflo read hi/lo combinationally; the result goes through the writeback mux into the register file.
- mthi/mtlo write HI/LO directly.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits; iteration count is WIDTH.

Ports:
clk  input  1  clock; all state updates on posedge.
reset  input  1  asynchronous, active-high reset.
start  input  1  request to begin an operation; sampled on posedge.
op  input  2  operation: 00 mult, 01 multu, 10 div, 11 divu; sampled with start.
a  input  WIDTH  rs operand (multiplicand / dividend); sampled with start.
b  input  WIDTH  rt operand (multiplier / divisor); sampled with start.
hi_we  input  1  mthi: load HI from wd.
lo_we  input  1  mtlo: load LO from wd.
wd  input  WIDTH  write data for mthi/mtlo.
busy  output  1  operation in progress; control stalls the pipeline while high.
done  output  1  one-cycle pulse, high for the cycle after HI/LO receive a result.
hi  output  WIDTH  HI register: product upper half, or remainder.
lo  output  WIDTH  LO register: product lower half, or quotient.

Behaviour:
- Reset is asynchronous, active-high; clock is clk.
- Reset values: hi=0, lo=0, busy=0, done=0, state=IDLE, iteration counter=0, internal operand registers=0.
- Reset mid-operation aborts the operation; nothing is written to HI/LO except the reset clear.
- State machine: IDLE -> CALC -> FIX -> IDLE.
- IDLE, start=1 at edge E0:
  - Latch op.
  - Latch magnitudes |a| and |b| when signed (op[0]=0), raw values when unsigned.
  - Record result signs: qsign = a[MSB]^b[MSB]; rsign = a[MSB] (signed ops only).
  - Clear accumulator, set counter=0, busy=1, go to CALC.
- CALC, edges E1..E_WIDTH: one iteration per edge, counter increments; leave to FIX when counter reaches WIDTH-1.
  - Multiply: shift-add, 2*WIDTH-bit accumulator, one multiplier bit per cycle, LSB first.
  - Divide: restoring algorithm, one quotient bit per cycle, MSB first; WIDTH+1-bit trial subtract.
- FIX, edge E_WIDTH+1:
  - Signed mult: negate the 2*WIDTH-bit product if qsign.
  - Signed div: negate quotient if qsign; negate remainder if rsign.
  - Write hi/lo, set busy=0, done=1, return to IDLE.
- done deasserts on the next edge.
- Latency: HI/LO are valid WIDTH+1 edges after the start edge (33 for WIDTH=32). busy is high for exactly WIDTH+1 cycles.
- Width rules:
  - Multiply: product is 2*WIDTH bits; upper half to hi, lower half to lo.
  - Divide: quotient to lo, remainder to hi.
  - Signed magnitude of the most negative value (0x80000000) is 0x80000000 treated as unsigned.
  - Negation is two's complement with wrap.
- Divide by zero (b=0, div or divu): still takes the full latency. Result overrides sign fix: lo=all ones, hi=a as originally sampled.
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. This falls out of the normal path; no special case is required.
- start while busy=1: ignored; the operation in flight is unaffected.
- start and done in the same cycle: start is accepted, since state is IDLE.
- hi_we/lo_we while busy=1: ignored.
- hi_we/lo_we in IDLE with start=1 on the same edge: start is taken, the writes are dropped.
- Otherwise hi_we/lo_we load on the posedge, independently of each other.
- op is don't-care unless start is accepted.

Test Plan:
- Reset, then mult a=0xFFFFFFFE b=0x00000003 -> busy high 33 cycles; done pulses once; hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- multu a=0xFFFFFFFE b=0x00000003 -> hi=0x00000002, lo=0xFFFFFFFA.
- multu 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- div a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- divu 100/7 -> lo=14, hi=2.
- divu a=100 b=0 -> lo=0xFFFFFFFF, hi=0x00000064.
- div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- Second start and hi_we (wd=0x12345678) pulsed at cycle 10 of a mult 5*6:
  - Both ignored; hi=0, lo=30 at completion.
  - Then lo_we with wd=0xCAFEF00D in IDLE -> lo=0xCAFEF00D, hi unchanged.
- Assert reset asynchronously mid-CALC (cycle 15 of a div) -> hi=lo=0, busy=0, done=0 immediately.
- After release, a new mult 3*4 completes normally: lo=12.
